// File: rtl/selftest_bus_arbiter.sv
// selftest_bus_arbiter
// Round-robin arbiter for four layer self-test units sharing one inter-layer
// bus. A granted owner drives the bus for up to HOLD_CYC cycles, or fewer if it
// drops its request. The bus then idles for GAP_CYC turnaround cycles before
// the next arbitration. Words carrying the 16'hBEEF frame marker are flagged and
// counted in a saturating counter.
module selftest_bus_arbiter #(
    parameter int HOLD_CYC = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic         div_8_clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [127:0] req_data,
    output logic [3:0]   gnt,
    output logic         bus_valid,
    output logic [31:0]  bus_data,
    output logic         frame_ok,
    output logic [7:0]   frame_cnt,
    output logic         busy,
    output logic [1:0]   last_owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYC);
    localparam logic [2:0] GAP_MAX  = 3'(GAP_CYC);
    localparam bit         HAS_GAP  = (GAP_CYC > 0);

    // Returns {found, index} of the first set request searched from ptr+1
    // upward with wrap-around; ptr itself has the lowest priority.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t      state_q,      state_d;
    logic [1:0]  rr_ptr_q,     rr_ptr_d;
    logic [3:0]  hold_cnt_q,   hold_cnt_d;
    logic [2:0]  gap_cnt_q,    gap_cnt_d;
    logic [3:0]  gnt_q,        gnt_d;
    logic [1:0]  last_owner_q, last_owner_d;
    logic [7:0]  frame_cnt_q,  frame_cnt_d;
    logic [2:0]  win_s;
    logic        bus_valid_s;
    logic [31:0] bus_data_s;
    logic        frame_ok_s;

    assign win_s       = rr_pick(req, rr_ptr_q);
    assign bus_valid_s = (state_q == ST_DRIVE);
    assign bus_data_s  = bus_valid_s ? req_data[{last_owner_q, 5'd0} +: 32] : 32'h0000_0000;
    assign frame_ok_s  = bus_valid_s && (bus_data_s[15:0] == 16'hBEEF);

    assign gnt        = gnt_q;
    assign bus_valid  = bus_valid_s;
    assign bus_data   = bus_data_s;
    assign frame_ok   = frame_ok_s;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = (state_q != ST_IDLE);
    assign last_owner = last_owner_q;

    // Next-state logic: arbitration, hold/turnaround counting and grant vector.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        gnt_d        = gnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (win_s[2]) begin
                    state_d      = ST_DRIVE;
                    gnt_d        = 4'b0001 << win_s[1:0];
                    last_owner_d = win_s[1:0];
                    rr_ptr_d     = win_s[1:0];
                    hold_cnt_d   = 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            ST_DRIVE: begin
                // The owner always gets this cycle; release is decided at its end.
                if ((hold_cnt_q >= HOLD_MAX) || !req[last_owner_q]) begin
                    gnt_d      = 4'b0000;
                    hold_cnt_d = 4'd0;
                    if (HAS_GAP) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 3'd1;
                    end else begin
                        state_d   = ST_IDLE;
                        gap_cnt_d = 3'd0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                gnt_d = 4'b0000;
                if (gap_cnt_q >= GAP_MAX) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = 3'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = 4'b0000;
                hold_cnt_d = 4'd0;
                gap_cnt_d  = 3'd0;
            end
        endcase
    end

    // Saturating count of marker words seen on the bus.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_ok_s && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge div_8_clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 2'd3;
            hold_cnt_q   <= 4'd0;
            gap_cnt_q    <= 3'd0;
            gnt_q        <= 4'b0000;
            last_owner_q <= 2'd0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            gnt_q        <= gnt_d;
            last_owner_q <= last_owner_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_selftest_bus_arbiter.sv
// Testbench for selftest_bus_arbiter (HOLD_CYC=2, GAP_CYC=1).
// Each vector row is one clock cycle: inputs applied after the rising edge,
// expected outputs queued, then popped and compared on the falling edge.
module tb_selftest_bus_arbiter;

    logic         div_8_clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic         bus_valid;
    logic [31:0]  bus_data;
    logic         frame_ok;
    logic [7:0]   frame_cnt;
    logic         busy;
    logic [1:0]   last_owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 div_8_clk = ~div_8_clk;

    selftest_bus_arbiter #(.HOLD_CYC(2), .GAP_CYC(1)) dut (
        .div_8_clk (div_8_clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .frame_ok  (frame_ok),
        .frame_cnt (frame_cnt),
        .busy      (busy),
        .last_owner(last_owner)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       mark;
        logic       glitch;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] lo;
        logic [7:0] fc;
    } vec_t;

    typedef struct {
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  lo;
        logic [7:0]  fc;
        logic        valid;
        logic [31:0] data;
        logic        fok;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    function automatic logic [31:0] word_of(input logic [1:0] i, input logic mark);
        case (i)
            2'd0:    return 32'h0000_1111;
            2'd1:    return mark ? 32'hAF12_BEEF : 32'hAF12_BEEE;
            2'd2:    return 32'h2222_2222;
            default: return 32'h3333_3333;
        endcase
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic mk, input logic gl,
                       input logic [3:0] g, input logic b, input logic [1:0] lo, input logic [7:0] fc);
        vec_t v;
        v.rst_n = r; v.req = rq; v.mark = mk; v.glitch = gl;
        v.gnt = g; v.busy = b; v.lo = lo; v.fc = fc;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got_e;
        rst_n    = v.rst_n;
        req      = v.req;
        req_data = {word_of(2'd3, v.mark), word_of(2'd2, v.mark),
                    word_of(2'd1, v.mark), word_of(2'd0, v.mark)};
        e.gnt   = v.gnt;
        e.busy  = v.busy;
        e.lo    = v.lo;
        e.fc    = v.fc;
        e.valid = (v.gnt != 4'b0000);
        e.data  = e.valid ? word_of(v.lo, v.mark) : 32'h0000_0000;
        e.fok   = e.valid && (e.data[15:0] == 16'hBEEF);
        sb_q.push_back(e);
        @(negedge div_8_clk);
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            got_e = sb_q.pop_front();
            check("gnt",        32'(gnt),        32'(got_e.gnt));
            check("busy",       32'(busy),       32'(got_e.busy));
            check("last_owner", 32'(last_owner), 32'(got_e.lo));
            check("frame_cnt",  32'(frame_cnt),  32'(got_e.fc));
            check("bus_valid",  32'(bus_valid),  32'(got_e.valid));
            check("bus_data",   bus_data,        got_e.data);
            check("frame_ok",   32'(frame_ok),   32'(got_e.fok));
        end
        if (v.glitch) begin
            // Reset pulse entirely between edges must be ignored.
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
        end
        @(posedge div_8_clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   drives;
        int   phase;
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = 128'd0;
        @(posedge div_8_clk);
        #1;

        //   rst   req     mk    gl    gnt     busy  lo     fc
        // reset with all requesting, then round robin 0,1,2,3,0
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        add(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 8'd0);
        add(1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 8'd0);
        // back to 0; owner drops during first DRIVE cycle -> single cycle
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        // early release by requester 2
        add(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'd0);
        // request only during GAP is lost
        add(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'd0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'd0);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'd0);
        // marker word from requester 1 for two cycles
        add(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 8'd0);
        add(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd0);
        add(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd1);
        add(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd2);
        // non-marker word: no count
        add(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'd2);
        add(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 8'd2);
        add(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 8'd2);
        // grant 3, reset mid-DRIVE, then requester 0 wins first
        add(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 8'd2);
        add(1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd2);
        add(1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        add(1'b1, 4'b1001, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'd0);
        add(1'b1, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'd0);
        add(1'b1, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Saturation: reset, then sole requester 1 with marker word held.
        v.rst_n = 1'b0; v.req = 4'b0010; v.mark = 1'b1; v.glitch = 1'b0;
        v.gnt = 4'b1000; v.busy = 1'b1; v.lo = 2'd3; v.fc = 8'd0;
        apply(v);
        drives = 0;
        for (int k = 0; k < 620; k++) begin
            phase   = k % 4;
            v.rst_n = 1'b1;
            v.gnt   = (phase == 1 || phase == 2) ? 4'b0010 : 4'b0000;
            v.busy  = (phase != 0);
            v.lo    = (k == 0) ? 2'd0 : 2'd1;
            v.fc    = (drives > 255) ? 8'hFF : 8'(drives);
            apply(v);
            if (v.gnt != 4'b0000) begin
                drives++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/selftest_bus_arbiter.md
SELFTEST_BUS_ARBITER -- requirements
Module: selftest_bus_arbiter

Interface
REQ-001 The block SHALL have one clock, div_8_clk, and a synchronous, active-low reset, rst_n; both are fixed.
REQ-002 Parameter HOLD_CYC, default 2: maximum DRIVE cycles per grant; legal range 1..15.
REQ-003 Parameter GAP_CYC, default 1: bus turnaround cycles after each grant; legal range 0..7.
REQ-004 div_8_clk  in  1  block clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 req  in  4  level request from each layer self-test unit; bit i belongs to requester i.
REQ-007 req_data  in  128  packed requester words; requester i drives bits [32i+31:32i].
REQ-008 gnt  out  4  one-hot grant; all zero when no owner.
REQ-009 bus_valid  out  1  shared inter-layer bus carries owner data this cycle.
REQ-010 bus_data  out  32  shared bus word.
REQ-011 frame_ok  out  1  current bus word carries the 16'hBEEF frame marker.
REQ-012 frame_cnt  out  8  saturating count of valid marker words.
REQ-013 busy  out  1  arbiter not in IDLE.
REQ-014 last_owner  out  2  index of the most recently granted requester.

Function
REQ-015 The FSM SHALL have three states: IDLE, DRIVE and GAP; no other state is reachable.
REQ-016 In IDLE with req==0, the state SHALL remain IDLE.
REQ-017 In IDLE with any req bit set, the winner SHALL be the first set bit searched from (rr_ptr+1) mod 4 upward, wrapping past 3.
REQ-018 On the next edge after REQ-017, the state SHALL become DRIVE, with gnt=onehot(winner), last_owner=winner, rr_ptr=winner and hold_cnt=1.
REQ-019 Request-to-grant latency from IDLE SHALL be exactly 1 cycle.
REQ-020 DRIVE SHALL last at least 1 cycle, regardless of the owner's req.
REQ-021 DRIVE SHALL end at the edge where hold_cnt==HOLD_CYC or where the owner's req is 0, whichever comes first.
REQ-022 While DRIVE continues, hold_cnt SHALL increment by 1 per cycle.
REQ-023 DRIVE exit SHALL go to GAP when GAP_CYC>0 and to IDLE when GAP_CYC==0; gnt SHALL clear on that same edge.
REQ-024 GAP SHALL last exactly GAP_CYC cycles with gnt=0 and SHALL then enter IDLE; requests are ignored during GAP.
REQ-025 Requests from non-owners during DRIVE SHALL be ignored; there is no preemption.
REQ-026 bus_valid SHALL be combinational and equal (state==DRIVE).
REQ-027 bus_data SHALL be combinational: req_data word of last_owner when bus_valid=1, else 32'h0.
REQ-028 frame_ok SHALL be combinational: bus_valid && bus_data[15:0]==16'hBEEF.
REQ-029 frame_cnt SHALL increment by 1 at each edge where frame_ok=1, saturating at 8'hFF with no wrap.
REQ-030 busy SHALL be combinational and equal (state!=IDLE).
REQ-031 A sole continuous requester SHALL regain the bus every HOLD_CYC+GAP_CYC+1 cycles.
REQ-032 With all four requesting continuously, grant order SHALL be 0,1,2,3,0,... with no requester skipped.
REQ-033 A req pulse that is 0 at the IDLE sampling edge SHALL be lost; requesters must hold req until granted.

Reset
REQ-034 rst_n==0 at an edge SHALL set state=IDLE, rr_ptr=3, hold_cnt=0, GAP counter=0, last_owner=0 and frame_cnt=0.
REQ-035 Reset SHALL therefore give gnt=0, bus_valid=0, bus_data=0, frame_ok=0 and busy=0.
REQ-036 Reset SHALL override every state, including mid-DRIVE; the first grant after reset goes to requester 0 if it is requesting.
REQ-037 rst_n changes between edges SHALL have no effect.

Verification
REQ-038 Reset: req=4'b1111, rst_n low for 2 edges -> gnt=0 and frame_cnt=0 throughout; 1 cycle after release, gnt=4'b0001.
REQ-039 Round robin: HOLD_CYC=2, GAP_CYC=1, req=4'b1111 held -> per-cycle gnt = 0000, 0001, 0001, 0000, 0000, 0010, 0010, ... with 4-cycle period and order 0,1,2,3,0.
REQ-040 Early release: req=4'b0100, dropped after the first DRIVE cycle -> exactly one cycle with gnt=4'b0100 and bus_valid=1, then GAP.
REQ-041 Marker: req[1]=1, req_data[63:32]=32'hAF12BEEF, HOLD_CYC=2 -> bus_data=32'hAF12BEEF and frame_ok=1 for 2 cycles; frame_cnt rises by 2; non-BEEF word gives frame_ok=0.
REQ-042 Saturation: force 300 marker words -> frame_cnt holds at 8'hFF.
REQ-043 Reset mid-DRIVE: assert rst_n=0 during gnt=4'b1000 -> next edge gnt=0 and busy=0; after release with req=4'b1001, grant goes to requester 0 first.
